rf_wport_arbiter: RTL and testbench

//  Shares the single register-file write port between the pipeline WB stage and a

---
 rtl/rf_wport_arbiter.sv | 137 +++++++++++++
 tb/tb_rf_wport_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - register-file write-port arbiter with long-latency result FIFO and scoreboard
module rf_wport_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    rd_mem_q [DEPTH];
  logic [4:0]    rd_mem_d [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic [31:0]   pend_q, pend_d;
  logic [SW-1:0] starve_q, starve_d;

  logic empty, full, wb_act, pop, push, starve;
  logic [4:0] head_rd;

  // Arbitration decode: WB always owns the port when it writes a real register.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    wb_act  = wb_we && (wb_rd != 5'd0);
    pop     = !wb_act && !empty;
    // lu_rd==0 results are acknowledged but never stored.
    push    = lu_valid && !full && (lu_rd != 5'd0);
    head_rd = rd_mem_q[rd_ptr_q];
    starve  = (starve_q == SW'(STARVE_MAX));
  end

  // Port select and hazard outputs, all zero-latency from inputs and registered state.
  always_comb begin
    rf_we    = 1'b0;
    rf_wa    = 5'd0;
    rf_wd    = 32'd0;
    if (wb_act) begin
      rf_we = 1'b1;
      rf_wa = wb_rd;
      rf_wd = wb_data;
    end else if (!empty) begin
      rf_we = 1'b1;
      rf_wa = head_rd;
      rf_wd = data_mem_q[rd_ptr_q];
    end
    lu_ready = !full;
    stall    = ((chk_rs != 5'd0) && pend_q[chk_rs]) ||
               ((chk_rt != 5'd0) && pend_q[chk_rt]) ||
               starve;
  end

  // Next-state for FIFO storage, pointers, pending bits and starvation counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    pend_d     = pend_q;
    starve_d   = starve_q;

    if (push) begin
      rd_mem_d[wr_ptr_q]   = lu_rd;
      data_mem_d[wr_ptr_q] = lu_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Clear first so a same-cycle issue to the same register keeps it pending.
    if (pop) begin
      pend_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      pend_d[issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;

    if (pop || empty) begin
      starve_d = '0;
    end else if (wb_act && !starve) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State registers; reset discards queued results and pending bits at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      starve_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= 5'd0;
        data_mem_q[i] <= 32'd0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      starve_q   <= starve_d;
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - scoreboard bench for rf_wport_arbiter
module tb_rf_wport_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .stall(stall),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall;
    logic        rdy;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  exp_t        exp_q[$];
  ent_t        mq[$];
  logic [31:0] mpend;
  int          mstarve;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    mpend   = 32'd0;
    mstarve = 0;
  endtask

  // Drive one cycle (called just after a rising edge), predict, compare at the falling edge.
  task automatic cycle(input logic i_wb_we, input logic [4:0] i_wb_rd, input logic [31:0] i_wb_data,
                       input logic i_lu_valid, input logic [4:0] i_lu_rd, input logic [31:0] i_lu_data,
                       input logic i_iv, input logic [4:0] i_ird,
                       input logic [4:0] i_rs, input logic [4:0] i_rt);
    exp_t e;
    exp_t g;
    ent_t n;
    logic act, full, was_empty, popped;
    wb_we = i_wb_we; wb_rd = i_wb_rd; wb_data = i_wb_data;
    lu_valid = i_lu_valid; lu_rd = i_lu_rd; lu_data = i_lu_data;
    issue_valid = i_iv; issue_rd = i_ird; chk_rs = i_rs; chk_rt = i_rt;

    act       = i_wb_we && (i_wb_rd != 5'd0);
    full      = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    e.rdy     = !full;
    e.stall   = ((i_rs != 0) && mpend[i_rs]) || ((i_rt != 0) && mpend[i_rt]) || (mstarve == STARVE_MAX);
    e.we = 1'b0; e.wa = 5'd0; e.wd = 32'd0;
    if (act) begin
      e.we = 1'b1; e.wa = i_wb_rd; e.wd = i_wb_data;
    end else if (!was_empty) begin
      e.we = 1'b1; e.wa = mq[0].rd; e.wd = mq[0].d;
    end
    exp_q.push_back(e);

    @(negedge clk);
    g = exp_q.pop_front();
    check("rf_we", {31'd0, rf_we}, {31'd0, g.we});
    if (g.we) begin
      check("rf_wa", {27'd0, rf_wa}, {27'd0, g.wa});
      check("rf_wd", rf_wd, g.wd);
    end else begin
      check("rf_wa_idle", {27'd0, rf_wa}, 32'd0);
      check("rf_wd_idle", rf_wd, 32'd0);
    end
    check("stall", {31'd0, stall}, {31'd0, g.stall});
    check("lu_ready", {31'd0, lu_ready}, {31'd0, g.rdy});

    popped = !act && !was_empty;
    if (popped) begin
      n = mq.pop_front();
      mpend[n.rd] = 1'b0;
    end
    if (i_lu_valid && !full && (i_lu_rd != 0)) begin
      n.rd = i_lu_rd; n.d = i_lu_data;
      mq.push_back(n);
    end
    if (i_iv && (i_ird != 0)) mpend[i_ird] = 1'b1;
    if (popped || was_empty) mstarve = 0;
    else if (act && mstarve < STARVE_MAX) mstarve++;

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] rs);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rs, 5'd0);
  endtask

  initial begin
    reset = 1'b1;
    wb_we = 0; wb_rd = 0; wb_data = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
    issue_valid = 0; issue_rd = 0; chk_rs = 5'd7; chk_rt = 5'd9;
    model_clear();
    #1;
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
    check("rst_rf_wd", rf_wd, 32'd0);
    check("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // WB-only write appears in the same cycle
    cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Issue to r8, result arrives later, idle drain, reader of r8 stalls until after pop
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd0, 5'd0);
    idle(5'd8);
    idle(5'd8);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hABCD, 1'b0, 5'd0, 5'd8, 5'd0);
    idle(5'd8);
    idle(5'd8);

    // Contention: queued r9 waits behind three WB writes
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h999, 1'b1, 5'd9, 5'd0, 5'd0);
    for (int i = 3; i <= 5; i++)
      cycle(1'b1, 5'(i), 32'h100 + i, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9);
    idle(5'd9);
    idle(5'd9);

    // Fill the FIFO under WB pressure, a fifth result is refused, then drain in order
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 5'd1, 32'h200 + i, 1'b1, 5'(10 + i), 32'h300 + i, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) idle(5'd0);

    // Starvation: nine blocked cycles, then the drain releases the forced stall
    cycle(1'b1, 5'd2, 32'h400, 1'b1, 5'd15, 32'h415, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 5'd2, 32'h401 + i, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0);
    idle(5'd0);

    // Register zero: no pending bit, no queued write, WB to r0 is ignored
    cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0);

    // Randomised traffic
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    for (int i = 0; i < 6; i++) idle(5'd0);

    // Reset mid-operation with two entries queued and r20 pending
    cycle(1'b1, 5'd3, 32'h500, 1'b1, 5'd20, 32'h520, 1'b1, 5'd20, 5'd0, 5'd0);
    cycle(1'b1, 5'd3, 32'h501, 1'b1, 5'd21, 32'h521, 1'b0, 5'd0, 5'd0, 5'd0);
    wb_we = 1'b0; lu_valid = 1'b0; chk_rs = 5'd20; chk_rt = 5'd21;
    #1 reset = 1'b1;
    #1;
    check("midrst_rf_we", {31'd0, rf_we}, 32'd0);
    check("midrst_lu_ready", {31'd0, lu_ready}, 32'd1);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    model_clear();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    idle(5'd20);
    idle(5'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
